// File: rtl/ntt_job_sched_pkg.sv
// ntt_job_sched_pkg: shared types and constants for the NTT job sequencer.
package ntt_job_sched_pkg;
    localparam int ML_KEM_K = 3;
    typedef enum logic [1:0] {OP_NTT_VEC, OP_MATVEC, OP_INNER} sched_op_t;
    typedef enum logic {NTT_A, PWM_AB} ntt_mode_t;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_DONE} sched_state_t;
endpackage

// File: rtl/ntt_job_sched_if.sv
// ntt_job_sched_if: job control, wrapper handshake and commit strobes of the NTT job sequencer.
interface ntt_job_sched_if
    import ntt_job_sched_pkg::*;
#(
    parameter int IDX_W = 4
);
    logic             start_i;
    sched_op_t        op_i;
    logic             abort_i;
    logic             ntt_done_i;
    logic             ntt_run_o;
    ntt_mode_t        ntt_mode_o;
    logic [IDX_W-1:0] idx_a_o;
    logic [IDX_W-1:0] idx_b_o;
    logic             res_valid_o;
    logic [IDX_W-1:0] res_idx_o;
    logic             acc_first_o;
    logic             row_last_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport master (
        output start_i, op_i, abort_i, ntt_done_i,
        input  ntt_run_o, ntt_mode_o, idx_a_o, idx_b_o, res_valid_o, res_idx_o,
               acc_first_o, row_last_o, busy_o, done_o, err_o
    );
    modport slave (
        input  start_i, op_i, abort_i, ntt_done_i,
        output ntt_run_o, ntt_mode_o, idx_a_o, idx_b_o, res_valid_o, res_idx_o,
               acc_first_o, row_last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/ntt_job_sched_idx_gen.sv
// ntt_job_sched_idx_gen: row/column job counters with wrap and last-job detection.
module ntt_job_sched_idx_gen
    import ntt_job_sched_pkg::*;
#(
    parameter int K  = ML_KEM_K,
    parameter int CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          adv_i,
    input  sched_op_t     op_i,
    output logic [CW-1:0] i_o,
    output logic [CW-1:0] j_o,
    output logic          last_o
);
    logic [CW-1:0] i_q, i_d, j_q, j_d;
    logic          vec, i_end, j_end, wrap;

    // Finishing the last job clears the counters so they never pass K-1.
    always_comb begin
        vec    = op_i == OP_NTT_VEC;
        i_end  = i_q == CW'(K - 1);
        j_end  = j_q == CW'(K - 1);
        last_o = vec ? i_end : (op_i == OP_MATVEC) ? (i_end && j_end) : j_end;
        wrap   = clr_i || (adv_i && last_o);
        i_d    = wrap ? '0 : (adv_i && (vec || j_end)) ? i_q + CW'(1) : i_q;
        j_d    = wrap ? '0 : (adv_i && !vec) ? (j_end ? '0 : j_q + CW'(1)) : j_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign i_o = i_q;
    assign j_o = j_q;
endmodule

// File: rtl/ntt_job_sched.sv
// ntt_job_sched: drives one shared NTT wrapper through NTT-vector, matrix-vector and inner-product jobs.
module ntt_job_sched
    import ntt_job_sched_pkg::*;
#(
    parameter int K     = ML_KEM_K,
    parameter int IDX_W = $clog2(K * K)
) (
    input logic            clk_i,
    input logic            rst_n_i,
    ntt_job_sched_if.slave bus
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    sched_state_t  state_q, state_d;
    sched_op_t     op_q, op_d;
    logic          err_q, err_d;
    logic          clr, adv, last, vec, com;
    logic [CW-1:0] i, j;

    ntt_job_sched_idx_gen #(.K(K), .CW(CW)) u_idx (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .clr_i  (clr),
        .adv_i  (adv),
        .op_i   (op_q),
        .i_o    (i),
        .j_o    (j),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q | (bus.ntt_done_i && state_q != S_WAIT);
        clr     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start_i) begin
                op_d    = bus.op_i;
                clr     = 1'b1;
                err_d   = 1'b0;
                state_d = (bus.op_i inside {OP_NTT_VEC, OP_MATVEC, OP_INNER}) ? S_ISSUE : S_DONE;
            end
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT:   if (bus.ntt_done_i) state_d = S_COMMIT;
            S_COMMIT: begin
                adv     = 1'b1;
                state_d = last ? S_DONE : S_ISSUE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort overrides any simultaneous wrapper done or commit advance.
        if (bus.abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            clr     = 1'b1;
            adv     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_NTT_VEC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign vec             = op_q == OP_NTT_VEC;
    assign com             = state_q == S_COMMIT;
    assign bus.ntt_run_o   = state_q == S_ISSUE;
    assign bus.ntt_mode_o  = vec ? NTT_A : PWM_AB;
    assign bus.idx_a_o     = (op_q == OP_MATVEC) ? IDX_W'(i) * IDX_W'(K) + IDX_W'(j)
                                                 : vec ? IDX_W'(i) : IDX_W'(j);
    assign bus.idx_b_o     = vec ? '0 : IDX_W'(j);
    assign bus.res_valid_o = com;
    assign bus.res_idx_o   = (op_q == OP_INNER) ? '0 : IDX_W'(i);
    assign bus.acc_first_o = com && (vec || j == '0);
    assign bus.row_last_o  = com && (vec || j == CW'(K - 1));
    assign bus.busy_o      = state_q != S_IDLE;
    assign bus.done_o      = state_q == S_DONE;
    assign bus.err_o       = err_q;
endmodule
